// File: rtl/ksa_share_arbiter.sv
// Round-robin front end for one shared, pipelined Kogge-Stone adder.
// Accepts one operation per cycle, registers the operands that drive the
// adder, tracks each in-flight operation with a tag pipeline, and steers
// the adder's sum back to the requester that issued it. Each requester
// may have at most one operation outstanding.
module ksa_share_arbiter #(
    parameter int unsigned BITS = 64,
    parameter int unsigned N    = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N*BITS-1:0] req_a,
    input  logic [N*BITS-1:0] req_b,
    input  logic [N-1:0]      req_c,
    output logic [BITS-1:0]   add_a,
    output logic [BITS-1:0]   add_b,
    output logic              add_c,
    input  logic [BITS:0]     add_s,
    output logic [N-1:0]      rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [BITS:0]     rsp_s
);

    // Per-requester outstanding flag (1 = PEND, 0 = IDLE)
    logic [N-1:0]   pend_q, pend_d;
    // Round-robin pointer: index with highest priority this cycle
    logic [IDW-1:0] ptr_q, ptr_d;

    // Issue register feeding the adder
    logic [BITS-1:0] add_a_q, add_b_q;
    logic            add_c_q;
    logic [BITS-1:0] sel_a, sel_b;
    logic            sel_c;

    // Tag pipeline, one stage per clock edge between grant and sum valid
    logic [LAT:0]   tag_vld_q;
    logic [IDW-1:0] tag_id_q [LAT+1];

    logic [N-1:0]   eligible;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           any_grant;
    logic           found;

    // Eligibility: requesting and idle; nothing is granted while in reset
    always_comb begin
        eligible = req_valid & ~pend_q & {N{rst_n}};
    end

    // Round-robin pick: first eligible at or above ptr, else lowest eligible (wrap)
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i] && (IDW'(i) >= ptr_q)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                grant_id = IDW'(i);
            end
        end
        any_grant = found;
    end

    assign req_ready = grant;

    // Operand select for the granted requester and next pointer value
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = 1'b0;
        ptr_d = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*BITS +: BITS];
                sel_b = req_b[i*BITS +: BITS];
                sel_c = req_c[i];
                ptr_d = IDW'((i + 1) % N);
            end
        end
    end

    // Response decode from the final tag stage; the sum is gated so it reads 0 when idle
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N; i++) begin
            rsp_valid[i] = tag_vld_q[LAT] && (tag_id_q[LAT] == IDW'(i));
        end
        rsp_id = tag_vld_q[LAT] ? tag_id_q[LAT] : '0;
        rsp_s  = tag_vld_q[LAT] ? add_s : '0;
    end

    // Outstanding tracking: set on handshake, cleared at the end of the response cycle
    always_comb begin
        pend_d = (pend_q | grant) & ~rsp_valid;
    end

    // Arbiter state: pending flags and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ptr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (any_grant) begin
                ptr_q <= ptr_d;
            end
        end
    end

    // Issue register: load on grant, otherwise hold the last operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q <= '0;
            add_b_q <= '0;
            add_c_q <= 1'b0;
        end else if (any_grant) begin
            add_a_q <= sel_a;
            add_b_q <= sel_b;
            add_c_q <= sel_c;
        end
    end

    assign add_a = add_a_q;
    assign add_b = add_b_q;
    assign add_c = add_c_q;

    // Tag pipeline: shifts every cycle, never stalls; reset discards in-flight ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int s = 0; s <= LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q[0] <= any_grant;
            tag_id_q[0]  <= grant_id;
            for (int s = 1; s <= LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

endmodule

// File: tb/tb_ksa_share_arbiter.sv
// Directed bench for ksa_share_arbiter: a cycle table plus hand sequences
// for outstanding limit, fairness, reset and idle hold.
module tb_ksa_share_arbiter;

    localparam int BITS = 64;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*BITS-1:0] req_a;
    logic [N*BITS-1:0] req_b;
    logic [N-1:0]      req_c;
    logic [BITS-1:0]   add_a;
    logic [BITS-1:0]   add_b;
    logic              add_c;
    logic [BITS:0]     add_s;
    logic [N-1:0]      rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [BITS:0]     rsp_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ksa_share_arbiter #(.BITS(BITS), .N(N), .IDW(IDW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .add_s     (add_s),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s)
    );

    // Shared adder model: LAT=2 edges from operands stable to sum valid, no reset
    logic [BITS:0] p0 = '0;
    logic [BITS:0] p1 = '0;
    always_ff @(posedge clk) begin
        p0 <= {1'b0, add_a} + {1'b0, add_b} + {{BITS{1'b0}}, add_c};
        p1 <= p0;
    end
    assign add_s = p1;

    typedef struct {
        bit            rst;
        logic [3:0]    valid;
        logic [63:0]   a;
        logic [63:0]   b;
        logic          c;
        logic [3:0]    ready;
        logic [3:0]    rv;
        logic [1:0]    rid;
        logic [64:0]   rs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, logic [3:0] valid, logic [63:0] a, logic [63:0] b,
                                logic c, logic [3:0] ready, logic [3:0] rv, logic [1:0] rid,
                                logic [64:0] rs);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a = a; v.b = b; v.c = c;
        v.ready = ready; v.rv = rv; v.rid = rid; v.rs = rs;
        return v;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester i gets a+i, b, c
    task automatic drive_ops(input logic [63:0] a, input logic [63:0] b, input logic c);
        for (int i = 0; i < N; i++) begin
            req_a[i*BITS +: BITS] = a + 64'(i);
            req_b[i*BITS +: BITS] = b;
            req_c[i]              = c;
        end
    endtask

    // Pulse reset for one cycle with all requesters valid; release at posedge+1
    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        check({tag, " rst ready"}, 65'(req_ready), 65'h0);
        check({tag, " rst add_a"}, 65'(add_a), 65'h0);
        check({tag, " rst add_b"}, 65'(add_b), 65'h0);
        check({tag, " rst add_c"}, 65'(add_c), 65'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'h0;
    endtask

    logic [3:0] gnt;
    int         gid;
    int         ngrant;
    bit         exp_os[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;

        // Reset state with requests pending at the inputs
        @(negedge clk);
        @(negedge clk);
        check("init ready", 65'(req_ready), 65'h0);
        check("init add_a", 65'(add_a), 65'h0);
        check("init add_b", 65'(add_b), 65'h0);
        check("init add_c", 65'(add_c), 65'h0);
        check("init rsp_valid", 65'(rsp_valid), 65'h0);
        check("init rsp_id", 65'(rsp_id), 65'h0);
        check("init rsp_s", rsp_s, 65'h0);

        // rst valid a b c | ready rv rid rs
        // Single op from requester 1 (a = FF..FE + 1), carry out into bit 64
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 0, 4'h2, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h2, 1, 65'h1_0000_0000_0000_0000));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        // Full contention from ptr = 0: a=i, b=10, c=1
        vecs.push_back(mk(0, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'hF, 64'h0, 64'd10, 1, 4'h1, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'hF, 64'h0, 64'd10, 1, 4'h2, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'hF, 64'h0, 64'd10, 1, 4'h4, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'hF, 64'h0, 64'd10, 1, 4'h8, 4'h1, 0, 65'd11));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h2, 1, 65'd12));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h4, 2, 65'd13));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h8, 3, 65'd14));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        // Reset mid-flight: grants to 0 and 1 are discarded, ptr and pend cleared
        vecs.push_back(mk(1, 4'h3, 64'd5, 64'd5, 0, 4'h1, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h3, 64'd5, 64'd5, 0, 4'h2, 4'h0, 0, 65'h0));
        vecs.push_back(mk(0, 4'h3, 64'd5, 64'd5, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h9, 64'd7, 64'd8, 1, 4'h1, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h1, 0, 65'd16));
        vecs.push_back(mk(1, 4'h0, 64'h0, 64'h0, 0, 4'h0, 4'h0, 0, 65'h0));

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst_n     = vecs[i].rst;
            req_valid = vecs[i].valid;
            drive_ops(vecs[i].a, vecs[i].b, vecs[i].c);
            @(negedge clk);
            check($sformatf("v%0d ready", i), 65'(req_ready), 65'(vecs[i].ready));
            check($sformatf("v%0d rsp_valid", i), 65'(rsp_valid), 65'(vecs[i].rv));
            check($sformatf("v%0d rsp_id", i), 65'(rsp_id), 65'(vecs[i].rid));
            check($sformatf("v%0d rsp_s", i), rsp_s, vecs[i].rs);
        end

        // Outstanding limit: requester 0 held valid; ready 1,0,0,0,1
        do_reset("os");
        req_valid = 4'h1;
        drive_ops(64'd3, 64'd4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("outstanding k%0d", k), 65'(req_ready[0]), 65'(exp_os[k]));
        end
        @(posedge clk); #1;
        req_valid = 4'h0;
        repeat (6) @(posedge clk);

        // Fairness: requesters 0 and 2 re-issue continuously; grants alternate 0,2,...
        do_reset("rr");
        for (int i = 0; i < N; i++) begin
            req_a[i*BITS +: BITS] = (i == 0) ? 64'd100 : 64'd200;
            req_b[i*BITS +: BITS] = (i == 0) ? 64'd1 : 64'd2;
            req_c[i]              = (i == 0) ? 1'b0 : 1'b1;
        end
        req_valid = 4'h5;
        ngrant    = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            gnt = req_valid & req_ready;
            if (gnt != 4'h0) begin
                gid = (gnt == 4'h1) ? 0 : (gnt == 4'h4) ? 2 : 99;
                check($sformatf("rr grant %0d", ngrant), 65'(gid), 65'((ngrant % 2 == 0) ? 0 : 2));
                ngrant++;
            end
            if (rsp_valid != 4'h0) begin
                check($sformatf("rr rsp_s k%0d", k), rsp_s,
                      (rsp_valid == 4'h1) ? 65'd101 : 65'd203);
            end
            if (k < 15) @(posedge clk);
        end
        check("rr grant count", 65'(ngrant), 65'd8);
        @(posedge clk); #1;
        req_valid = 4'h0;
        repeat (4) @(posedge clk);

        // Idle hold: last issue was requester 2 (200, 2, 1)
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("idle k%0d hold", k), {add_c, add_a}, {1'b1, 64'd200});
            check($sformatf("idle k%0d add_b", k), 65'(add_b), 65'd2);
            check($sformatf("idle k%0d rsp", k), {rsp_valid, rsp_id, rsp_s}, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ksa_share_arbiter.md
Name: ksa_share_arbiter

Overview:
- Round-robin scheduler that shares one pipelined Kogge-Stone adder (registered inputs and outputs, fixed latency) among N requesters.
- Accepts at most one operation per cycle through a valid/ready handshake and drives the adder's operand inputs from an issue register.
- Tracks each in-flight operation with a tag pipeline and routes the adder's sum back to the issuing requester.
- Enforces at most one outstanding operation per requester.

Parameters:
- BITS, 64, operand width; the adder sum is BITS+1.
- N, 4, number of requesters (2..16).
- IDW, 2, requester-id width; 2^IDW >= N.
- LAT, 2, adder latency in clock edges from operands stable at add_a/add_b/add_c to sum valid on add_s.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N  per-requester operation request.
- req_ready  out  N  per-requester accept; combinational.
- req_a  in  N*BITS  operand A; requester i occupies bits [i*BITS +: BITS].
- req_b  in  N*BITS  operand B; same packing as req_a.
- req_c  in  N  carry-in per requester.
- add_a  out  BITS  operand A to the shared adder; registered.
- add_b  out  BITS  operand B to the shared adder; registered.
- add_c  out  1  carry-in to the shared adder; registered.
- add_s  in  BITS+1  sum from the shared adder.
- rsp_valid  out  N  one-hot result strobe, one cycle per operation.
- rsp_id  out  IDW  id of the requester being answered; 0 when no rsp_valid bit is set.
- rsp_s  out  BITS+1  result; equals add_s when any rsp_valid bit is set, 0 otherwise.

Behaviour:
- Per-requester state: IDLE or PEND.
  - IDLE -> PEND on the handshake edge (req_valid[i] & req_ready[i]).
  - PEND -> IDLE on the edge ending the cycle in which rsp_valid[i] = 1.
  - A requester in PEND never sees req_ready[i] = 1.
- Eligibility: requester i is eligible when req_valid[i] = 1 and it is in IDLE.
- Arbitration:
  - Round-robin pointer ptr gives highest priority to ptr, then ptr+1, and so on, modulo N.
  - Exactly one eligible requester gets req_ready = 1; all other req_ready bits are 0.
  - If no requester is eligible, req_ready = 0 and ptr is unchanged.
  - On a grant to requester g, ptr <= (g+1) mod N.
  - req_ready[i] may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Issue:
  - On the handshake edge, add_a/add_b/add_c load the granted requester's operands.
  - Tag stage 0 loads {valid=1, id=g}.
  - Cycles without a grant load tag valid=0; add_a/add_b/add_c hold their last values.
- Tag pipeline: LAT+1 stages, shifting every cycle with no stall.
  - The final stage drives rsp_valid (decoded one-hot from id) and rsp_id.
  - Handshake in cycle t gives rsp_valid in cycle t+1+LAT (cycle t+3 for LAT=2).
- Throughput and ordering:
  - One issue per cycle is sustained while distinct requesters are eligible.
  - Responses return in issue order.
  - There is no response backpressure; the requester must take rsp_s in the strobe cycle.
- Re-issue: the earliest next handshake for the same requester is cycle t+2+LAT.
- Arithmetic: the block does not modify data; rsp_s is the adder's full BITS+1 result including carry-out.
- Reset values (rst_n = 0, asynchronous):
  - Every requester in IDLE, ptr = 0, all tag valids 0.
  - add_a = 0, add_b = 0, add_c = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_s = 0.
  - req_ready = 0 while rst_n = 0.
- Reset mid-operation:
  - In-flight operations are discarded; no rsp_valid is emitted for them even though add_s keeps changing.
  - After release, the first handshake is possible in the first cycle with rst_n = 1.
- Simultaneous events:
  - All N requesters valid in the same cycle: grants are serviced in order ptr, ptr+1, ... on consecutive cycles.
  - A response to one requester and a grant to another in the same cycle are independent and both take effect.

Test Plan:
- Single op, N=4, LAT=2: req 1 sends a=0xFFFF_FFFF_FFFF_FFFF, b=1, c=0 in cycle 5 -> add_a/add_b/add_c valid from cycle 6; rsp_valid=4'b0010, rsp_id=1, rsp_s=0x1_0000_0000_0000_0000 in cycle 8; no other rsp_valid bits set.
- Full contention: all 4 valid from cycle 2, ptr=0, each req i sends a=i, b=10, c=1 -> grants 0,1,2,3 in cycles 2-5; responses in cycles 5-8 with rsp_s = 11,12,13,14 and rsp_id = 0,1,2,3.
- Outstanding limit: req 0 holds req_valid high continuously -> req_ready[0] high in cycle 2, low in cycles 3-5, high again in cycle 6.
- Round-robin fairness: req 0 and req 2 continuously valid and re-issuing -> grants alternate 0,2,0,2; neither waits more than one grant slot once eligible.
- Reset mid-flight: grants in cycles 3 and 4, rst_n low in cycle 5 -> rsp_valid stays 0 through cycle 10; add_a/add_b/add_c = 0 and ptr = 0 after reset.
- Idle hold: no requests for 20 cycles after one op -> add_a/add_b/add_c retain the last operands; rsp_valid = 0, rsp_id = 0, rsp_s = 0.
